crtc_timing: RTL and testbench
==============================

# crtc_timing

Video timing generator for the PET's CRTC. It consumes the register values the CPU writes into the CRTC register file and produces the beam-side outputs: horizontal and vertical sync, display enable, refresh memory address (MA) and raster address (RA). It follows MC6845/6545 non-interlaced semantics with no cursor or light pen, and feeds the video fetch/shift path.

## Interface

Parameters:
- CLKS_PER_CHAR, 16, clk16 cycles per character time (1 MHz char clock at 16 MHz).

Ports:
- clk16  in  1  system clock, 16 MHz.
- res_b  in  1  asynchronous, active-low reset.
- r0_h_total  in  8  horizontal total, in characters minus 1.
- r1_h_displayed  in  8  displayed characters per line.
- r2_h_sync_pos  in  8  character index where hsync starts.
- r3_sync_width  in  8  [3:0] hsync width in chars (0 = no hsync); [7:4] vsync width in lines (0 = 16).
- r4_v_total  in  7  vertical total, in character rows minus 1.
- r5_v_adjust  in  5  extra scan lines after the last row.
- r6_v_displayed  in  7  displayed character rows.
- r7_v_sync_pos  in  7  row where vsync starts.
- r9_max_scan  in  5  scan lines per row minus 1.
- r12_r13_start  in  14  display start address, {R12[5:0], R13}.
- char_ce  out  1  one-clk16 pulse at each character boundary.
- ma  out  14  refresh memory address.
- ra  out  5  raster (scan line within row).
- de  out  1  display enable.
- hsync  out  1  active-high horizontal sync.
- vsync  out  1  active-high vertical sync.

## Operation

- **Divider.** 0..CLKS_PER_CHAR-1, free-running. Internal `ce` is true when the divider is at its maximum. All counters below advance only on `ce`.
- **h_count (8 bit).**
  - If h_count == R0: h_count <= 0 and a line end occurs.
  - Otherwise h_count increments.
  - Equality compare only. If R0 is lowered below h_count, the counter runs on and wraps 255 -> 0.
- **hde** = (h_count < R1).
- **Hsync.**
  - Set when h_count == R2 and R3[3:0] != 0.
  - Cleared after R3[3:0] characters by a 4-bit width counter.
  - A new match while active restarts the width counter.
- **Line end, vertical state.**
  - NORMAL state:
    - If ra != R9: ra++.
    - If ra == R9: ra <= 0 and row++ (7-bit, wraps 127 -> 0).
    - If ra == R9 and row == R4: go to ADJUST if R5 != 0, otherwise frame end.
  - ADJUST state: ra counts adjust lines from 0. When the count == R5-1, frame end.
  - Frame end: row <= 0, ra <= 0, ma_row <= r12_r13_start, state <= NORMAL.
- **vde** = (row < R6) and state == NORMAL.
- **de** = hde && vde.
- **Vsync.**
  - Set at the line end that starts row == R7 with ra == 0.
  - Lasts R3[7:4] lines (0 = 16), counted on line ends.
- **MA.**
  - ma = ma_row + h_count, modulo 2^14.
  - At a line end with ra == R9 (NORMAL state): ma_row <= ma_row + R1, modulo 2^14.
- **Register inputs** are sampled live every `ce`. Changes take effect on the next `ce`, except start address, which is latched only at frame end.

## Timing

- **Reset values:** all outputs 0; divider, h_count, ra, row and ma_row are 0; state NORMAL; sync width counters 0.
- **First boundary after reset:** the first `ce` loads ma_row <= r12_r13_start (reset acts as a pending frame end).
- **Registered outputs:** ma, ra, de, hsync and vsync reflect the counter state one clk16 after `ce` and are stable for CLKS_PER_CHAR cycles.
- **char_ce** is registered `ce`. It is high in the same cycle that the outputs update.
- **Reset mid-line or mid-frame:** immediate return to reset values. No partial sync pulse is extended.
- **Simultaneous events:**
  - Frame end and vsync start in the same line end: frame end applies first, then vsync evaluates with row = 0.
  - Hsync start and line end in the same `ce`: both take effect.
- **Degenerate registers:**
  - R1 > R0: de stays high through the whole line.
  - R6 > R4: vde is high for all NORMAL rows.

## Test plan

- **PET defaults** (R0=0x31, R1=0x28, R2=0x29, R3=0x0F, R4=0x28, R5=5, R6=0x19, R7=0x21, R9=7, start=0):
  - hsync period 800 clk16, high 240 clk16, rising 656 clk16 after line start.
  - Frame 333 lines = 266400 clk16.
  - vsync high 16 lines, starting at line 264.
- **Same config, de/MA check:**
  - 8000 de characters per frame, on lines 0-199 only.
  - ma at row 1, line 8, char 0 = 40.
  - Last visible ma = 999.
  - ra cycles 0-7.
- **Start address change:** write start=0x1000 mid-frame.
  - The current frame is unchanged.
  - The next frame's first ma = 0x1000.
  - start=0x3FF0: ma wraps to 0x0000 after 0x3FFF.
- **Zero widths:**
  - R3=0x00: hsync never asserts; vsync lasts 16 lines.
  - R5=0: the frame is exactly (R4+1)*(R9+1) lines = 328.
- **Mid-line R0 shrink:** set R0=0x10 while h_count=0x20. h_count runs to 255, wraps to 0, then lines are 17 chars.
- **Reset:** assert res_b low mid-vsync. All outputs go to 0 immediately; after release, the first char_ce occurs 16 clk16 later with ma=start.

Source files
------------

// File: rtl/crtc_timing.sv
// MC6845/6545-style beam timing for the PET CRTC: turns the live register file
// into char_ce, MA, RA, display enable and active-high syncs (no interlace, cursor or light pen).
module crtc_timing #(
  parameter int CLKS_PER_CHAR = 16
) (
  input  logic        clk16,
  input  logic        res_b,
  input  logic [7:0]  r0_h_total,
  input  logic [7:0]  r1_h_displayed,
  input  logic [7:0]  r2_h_sync_pos,
  input  logic [7:0]  r3_sync_width,
  input  logic [6:0]  r4_v_total,
  input  logic [4:0]  r5_v_adjust,
  input  logic [6:0]  r6_v_displayed,
  input  logic [6:0]  r7_v_sync_pos,
  input  logic [4:0]  r9_max_scan,
  input  logic [13:0] r12_r13_start,
  output logic        char_ce,
  output logic [13:0] ma,
  output logic [4:0]  ra,
  output logic        de,
  output logic        hsync,
  output logic        vsync
);

  localparam int DIV_W = (CLKS_PER_CHAR > 1) ? $clog2(CLKS_PER_CHAR) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_CHAR - 1);

  typedef enum logic {V_NORMAL = 1'b0, V_ADJUST = 1'b1} v_state_t;

  logic [DIV_W-1:0] div;
  logic             ce;
  logic             frame_pending;
  v_state_t         state, state_nx;
  logic [7:0]       h_count, h_count_nx;
  logic [4:0]       ra_cnt, ra_cnt_nx;
  logic [6:0]       row, row_nx;
  logic [13:0]      ma_row, ma_row_nx;
  logic [3:0]       hs_cnt, hs_cnt_nx;
  logic [4:0]       vs_cnt, vs_cnt_nx;
  logic             line_end, frame_end;
  logic [13:0]      ma_nx;
  logic             de_nx;

  assign ce = (div == DIV_MAX);

  // Next counter state for the coming character; outputs are registered from it
  // so they change in the same cycle that char_ce is high.
  always_comb begin
    state_nx   = state;
    h_count_nx = h_count + 8'd1;
    ra_cnt_nx  = ra_cnt;
    row_nx     = row;
    ma_row_nx  = ma_row;
    line_end   = 1'b0;
    frame_end  = 1'b0;

    if (frame_pending) begin
      h_count_nx = 8'd0;
      line_end   = 1'b1;
      frame_end  = 1'b1;
    end else if (h_count == r0_h_total) begin
      h_count_nx = 8'd0;
      line_end   = 1'b1;
      case (state)
        V_NORMAL: begin
          if (ra_cnt != r9_max_scan) begin
            ra_cnt_nx = ra_cnt + 5'd1;
          end else begin
            ra_cnt_nx = 5'd0;
            row_nx    = row + 7'd1;
            ma_row_nx = ma_row + {6'd0, r1_h_displayed};
            if (row == r4_v_total) begin
              if (r5_v_adjust != 5'd0) state_nx = V_ADJUST;
              else                     frame_end = 1'b1;
            end
          end
        end
        default: begin
          if (ra_cnt == r5_v_adjust - 5'd1) frame_end = 1'b1;
          else                              ra_cnt_nx = ra_cnt + 5'd1;
        end
      endcase
    end

    if (frame_end) begin
      state_nx  = V_NORMAL;
      row_nx    = 7'd0;
      ra_cnt_nx = 5'd0;
      ma_row_nx = r12_r13_start;
    end

    hs_cnt_nx = (hs_cnt != 4'd0) ? hs_cnt - 4'd1 : 4'd0;
    if (h_count_nx == r2_h_sync_pos && r3_sync_width[3:0] != 4'd0)
      hs_cnt_nx = r3_sync_width[3:0];

    // Vsync is judged after any frame end, so a row-0 sync position fires at frame start.
    vs_cnt_nx = vs_cnt;
    if (line_end && vs_cnt != 5'd0) vs_cnt_nx = vs_cnt - 5'd1;
    if (line_end && state_nx == V_NORMAL && row_nx == r7_v_sync_pos && ra_cnt_nx == 5'd0)
      vs_cnt_nx = (r3_sync_width[7:4] == 4'd0) ? 5'd16 : {1'b0, r3_sync_width[7:4]};

    ma_nx = ma_row_nx + {6'd0, h_count_nx};
    de_nx = (h_count_nx < r1_h_displayed) && (row_nx < r6_v_displayed) && (state_nx == V_NORMAL);
  end

  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      div           <= '0;
      char_ce       <= 1'b0;
      frame_pending <= 1'b1;
      state         <= V_NORMAL;
      h_count       <= 8'd0;
      ra_cnt        <= 5'd0;
      row           <= 7'd0;
      ma_row        <= 14'd0;
      hs_cnt        <= 4'd0;
      vs_cnt        <= 5'd0;
      ma            <= 14'd0;
      ra            <= 5'd0;
      de            <= 1'b0;
      hsync         <= 1'b0;
      vsync         <= 1'b0;
    end else begin
      div     <= ce ? '0 : div + DIV_W'(1);
      char_ce <= ce;
      if (ce) begin
        frame_pending <= 1'b0;
        state         <= state_nx;
        h_count       <= h_count_nx;
        ra_cnt        <= ra_cnt_nx;
        row           <= row_nx;
        ma_row        <= ma_row_nx;
        hs_cnt        <= hs_cnt_nx;
        vs_cnt        <= vs_cnt_nx;
        ma            <= ma_nx;
        ra            <= ra_cnt_nx;
        de            <= de_nx;
        hsync         <= (hs_cnt_nx != 4'd0);
        vsync         <= (vs_cnt_nx != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_crtc_timing.sv
// Bench for crtc_timing: per-character expectations from a line/frame position model,
// popped and compared by a monitor on every char_ce.
module tb_crtc_timing;

  localparam int CPC = 4;

  logic        clk16 = 1'b0;
  logic        res_b = 1'b1;
  logic [7:0]  r0_h_total, r1_h_displayed, r2_h_sync_pos, r3_sync_width;
  logic [6:0]  r4_v_total, r6_v_displayed, r7_v_sync_pos;
  logic [4:0]  r5_v_adjust, r9_max_scan;
  logic [13:0] r12_r13_start;
  logic        char_ce;
  logic [13:0] ma;
  logic [4:0]  ra;
  logic        de, hsync, vsync;

  crtc_timing #(.CLKS_PER_CHAR(CPC)) dut (
    .clk16(clk16), .res_b(res_b),
    .r0_h_total(r0_h_total), .r1_h_displayed(r1_h_displayed),
    .r2_h_sync_pos(r2_h_sync_pos), .r3_sync_width(r3_sync_width),
    .r4_v_total(r4_v_total), .r5_v_adjust(r5_v_adjust),
    .r6_v_displayed(r6_v_displayed), .r7_v_sync_pos(r7_v_sync_pos),
    .r9_max_scan(r9_max_scan), .r12_r13_start(r12_r13_start),
    .char_ce(char_ce), .ma(ma), .ra(ra), .de(de), .hsync(hsync), .vsync(vsync)
  );

  // clock / reset
  always #5 clk16 = ~clk16;

  int checks = 0;
  int errors = 0;
  logic [21:0] exp_q[$];   // {ma, ra, de, hsync, vsync}

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp_v, $time);
    end
  endfunction

  // reference model: position by line/frame arithmetic
  int          m_n, m_c, m_line, m_labs, hs_at, vs_at;
  bit          hs_ok, vs_ok;
  logic [13:0] m_start;

  task automatic model_step();
    int vper, nl, fl, row, rr, vw, hw;
    bit normal, new_line, e_de, e_hs, e_vs;
    logic [13:0] e_ma;
    new_line = 1'b0;
    if (m_n == 0) begin
      m_c = 0; m_line = 0; m_labs = 0; m_start = r12_r13_start; new_line = 1'b1;
    end else if (m_c == int'(r0_h_total)) begin
      m_c = 0; m_labs++; new_line = 1'b1;
      fl = (int'(r4_v_total) + 1) * (int'(r9_max_scan) + 1) + int'(r5_v_adjust);
      m_line++;
      if (m_line == fl) begin
        m_line = 0;
        m_start = r12_r13_start;
      end
    end else begin
      m_c = (m_c + 1) % 256;
    end
    vper = int'(r9_max_scan) + 1;
    nl   = (int'(r4_v_total) + 1) * vper;
    if (m_line < nl) begin
      normal = 1'b1; row = m_line / vper; rr = m_line % vper;
    end else begin
      normal = 1'b0; row = int'(r4_v_total) + 1; rr = m_line - nl;
    end
    hw = int'(r3_sync_width[3:0]);
    vw = (r3_sync_width[7:4] == 4'd0) ? 16 : int'(r3_sync_width[7:4]);
    if (m_c == int'(r2_h_sync_pos) && hw != 0) begin hs_ok = 1'b1; hs_at = m_n; end
    if (new_line && normal && row == int'(r7_v_sync_pos) && rr == 0) begin vs_ok = 1'b1; vs_at = m_labs; end
    e_ma = 14'((int'(m_start) + row * int'(r1_h_displayed) + m_c) % 16384);
    e_de = (m_c < int'(r1_h_displayed)) && normal && (row < int'(r6_v_displayed));
    e_hs = hs_ok && ((m_n - hs_at) < hw);
    e_vs = vs_ok && ((m_labs - vs_at) < vw);
    exp_q.push_back({e_ma, 5'(rr), e_de, e_hs, e_vs});
    m_n++;
  endtask

  // driver tasks
  task automatic run_chars(input int count);
    for (int i = 0; i < count; i++) begin
      model_step();
      repeat (CPC) @(negedge clk16);
      #1;
    end
  endtask

  task automatic reset_assert();
    @(negedge clk16); #1;
    res_b = 1'b0;
    #1;
    check("reset_outputs", 32'({char_ce, ma, ra, de, hsync, vsync}), 32'd0);
    exp_q.delete();
  endtask

  task automatic reset_release();
    m_n = 0; hs_ok = 1'b0; vs_ok = 1'b0;
    repeat (2) @(negedge clk16);
    #1;
    res_b = 1'b1;
  endtask

  task automatic end_phase();
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_regs(input logic [7:0] h0, h1, h2, s3, input logic [6:0] v4, input logic [4:0] v5,
                          input logic [6:0] v6, v7, input logic [4:0] s9, input logic [13:0] st);
    r0_h_total = h0; r1_h_displayed = h1; r2_h_sync_pos = h2; r3_sync_width = s3;
    r4_v_total = v4; r5_v_adjust = v5; r6_v_displayed = v6; r7_v_sync_pos = v7;
    r9_max_scan = s9; r12_r13_start = st;
  endtask

  // scoreboard monitor
  logic [21:0] act, last_exp;
  logic        res_q = 1'b0;
  bit          hold_bad, first_pending;
  int          rel_cnt, mon_idx;

  always @(negedge clk16) begin
    if (!res_b) begin
      hold_bad = 1'b0; last_exp = '0; first_pending = 1'b0; mon_idx = 0;
    end else begin
      if (!res_q) begin first_pending = 1'b1; rel_cnt = 0; end
      act = {ma, ra, de, hsync, vsync};
      if (first_pending) begin
        rel_cnt++;
        if (rel_cnt > 4 * CPC && char_ce !== 1'b1) begin
          check("first_char_ce_timeout", 32'(rel_cnt), 32'(CPC));
          first_pending = 1'b0;
        end
      end
      if (char_ce === 1'b1) begin
        if (first_pending) begin
          check("first_char_ce_delay", 32'(rel_cnt), 32'(CPC));
          first_pending = 1'b0;
        end
        check("hold_between_ce", 32'(hold_bad), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_char_ce", 32'd1, 32'd0);
        end else begin
          last_exp = exp_q.pop_front();
          check($sformatf("char%0d_{ma,ra,de,hs,vs}", mon_idx), 32'(act), 32'(last_exp));
        end
        mon_idx++;
        hold_bad = 1'b0;
      end else if (act !== last_exp) begin
        hold_bad = 1'b1;
      end
    end
    res_q = res_b;
  end

  initial begin
    int ll, fl;
    set_regs(8'h31, 8'h28, 8'h29, 8'h0F, 7'h28, 5'd5, 7'h19, 7'h21, 5'd7, 14'd0);

    // PET horizontal timing, short frame; start address moved mid-frame twice
    reset_assert();
    set_regs(8'h31, 8'h28, 8'h29, 8'h2F, 7'd6, 5'd3, 7'd5, 7'd5, 5'd3, 14'd0);
    reset_release();
    run_chars(700);
    r12_r13_start = 14'h1000;
    run_chars(1550);
    r12_r13_start = 14'h3FF0;
    run_chars(1875);
    end_phase();

    // reset lands inside vsync; then PET vertical with zero sync widths and no adjust
    reset_assert();
    set_regs(8'd9, 8'd8, 8'd3, 8'h00, 7'h28, 5'd0, 7'h19, 7'h21, 5'd7, 14'h0123);
    reset_release();
    run_chars(3400);
    end_phase();

    // randomized configurations, including R1 > R0 and R6 > R4
    for (int k = 0; k < 3; k++) begin
      reset_assert();
      r0_h_total     = 8'($urandom_range(12, 30));
      r1_h_displayed = 8'($urandom_range(0, int'(r0_h_total) + 3));
      r2_h_sync_pos  = 8'($urandom_range(0, int'(r0_h_total)));
      r3_sync_width  = 8'($urandom);
      r4_v_total     = 7'($urandom_range(2, 5));
      r5_v_adjust    = 5'($urandom_range(0, 3));
      r6_v_displayed = 7'($urandom_range(0, int'(r4_v_total) + 2));
      r7_v_sync_pos  = 7'($urandom_range(0, int'(r4_v_total)));
      r9_max_scan    = 5'($urandom_range(0, 3));
      r12_r13_start  = 14'($urandom);
      reset_release();
      ll = int'(r0_h_total) + 1;
      fl = (int'(r4_v_total) + 1) * (int'(r9_max_scan) + 1) + int'(r5_v_adjust);
      run_chars(fl * ll + int'($urandom_range(ll, 4 * ll)));
      end_phase();
    end

    // R0 lowered below h_count: line runs through 255, then 17-char lines
    reset_assert();
    set_regs(8'h31, 8'h28, 8'h29, 8'h3A, 7'd3, 5'd1, 7'd2, 7'd1, 5'd1, 14'h0200);
    reset_release();
    run_chars(83);
    r0_h_total = 8'h10;
    run_chars(1000);
    end_phase();

    reset_assert();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
